insn_fetch: RTL
===============

Name: insn_fetch

Overview:
Instruction fetch stage directly upstream of the instruction decoder. Owns the program counter and issues read requests to instruction memory over a level req/ack handshake. Holds the returned 8-bit instruction, with its PC, in a single-entry output register presented to the decoder. Supports downstream stall and a one-cycle PC redirect for jumps and branches.

Parameters:
PC_WIDTH, 8, width of program counter and memory address
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  read request; held high until imem_ack
imem_addr  output  PC_WIDTH  read address (req_addr register), stable while imem_req=1
imem_rdata  input  8  instruction data, valid when imem_ack=1
imem_ack  input  1  one-cycle completion pulse; ignored when imem_req=0
stall  input  1  decoder cannot accept insn this cycle
redirect_en  input  1  one-cycle pulse: load redirect_pc into PC, flush
redirect_pc  input  PC_WIDTH  redirect target
insn  output  8  instruction to decoder
insn_valid  output  1  insn/insn_pc hold a valid instruction
insn_pc  output  PC_WIDTH  address insn was fetched from

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, req_addr=0, state=IDLE, insn=0, insn_pc=0, insn_valid=0, imem_req=0.
- imem_req=1 exactly in states REQ and DROP. imem_addr=req_addr, combinational from the register.
- Consume event: insn_valid=1 and stall=0 at a rising edge. insn_valid clears unless a new capture occurs in the same edge.
- IDLE:
  - redirect_en: pc<=redirect_pc; req_addr<=redirect_pc; insn_valid<=0; go to REQ.
  - Else if insn_valid=0 or consume: req_addr<=pc; go to REQ.
  - Else stay in IDLE (stalled, output held).
- REQ (output register is always empty here):
  - ack=1, redirect_en=0: insn<=imem_rdata; insn_pc<=req_addr; insn_valid<=1; pc<=pc+1; go to IDLE.
  - ack=1, redirect_en=1: data discarded; pc<=redirect_pc; req_addr<=redirect_pc; stay in REQ (new request next cycle).
  - ack=0, redirect_en=1: pc<=redirect_pc; go to DROP. req_addr is unchanged; the old request stays outstanding.
  - ack=0, redirect_en=0: stay in REQ.
- DROP (old request in flight; its data is stale):
  - ack=1: data discarded; req_addr<=pc; go to REQ.
  - redirect_en=1: pc<=redirect_pc. If ack is also 1, the new pc is used for req_addr.
- Redirect priority: redirect_en beats ack capture and stall. A redirect always clears insn_valid on the same edge.
- PC arithmetic is modulo 2^PC_WIDTH: pc=2^PC_WIDTH-1 increments to 0, no flag.
- Latency: fetch issued on cycle N with zero-wait memory (ack on cycle N) gives insn_valid=1 at N+1. Peak throughput is 1 instruction per 2 cycles.
- Reset mid-request: all state clears immediately and imem_req drops. A later ack is ignored because imem_req=0.
- Output stability: insn and insn_pc change only on capture. insn_valid never drops without a consume or a redirect.

Decomposition:
- Shared package (cpu_pkg):
  - fetch state encodings: IDLE=2'd0, REQ=2'd1, DROP=2'd2
  - instruction width constant (8)
  - default RESET_PC
- No sub-module. PC register, req_addr, output register and the 3-state FSM fit in one module.

Test Plan:
- Reset then zero-wait memory returning 0xA1,0xB2,0xC3 with stall=0 -> insn_valid pulses every 2nd cycle; insn/insn_pc = A1/0, B2/1, C3/2.
- stall=1 held 5 cycles after the first capture -> insn=0xA1, insn_pc=0 held stable; imem_req=0 during stall; fetch of addr 1 issues the cycle after stall drops.
- Memory ack latency 3 cycles -> imem_req high with imem_addr constant for 3 cycles; a single capture follows.
- redirect_en with redirect_pc=0x40 while REQ to addr 0x05 is pending (ack 2 cycles later) -> DROP entered; stale data discarded, insn_valid stays 0; next imem_addr=0x40; captured insn_pc=0x40.
- redirect_en in the same cycle as ack -> ack data not captured; next request to redirect_pc; redirect while insn_valid=1 and stall=1 -> insn_valid cleared next edge.
- PC wrap: RESET_PC=0xFE, fetch 3 instructions -> insn_pc sequence 0xFE, 0xFF, 0x00; async rst asserted mid-REQ -> imem_req and insn_valid drop at once, pc reloads 0xFE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: state encodings, instruction width
// and default reset PC.
package cpu_pkg;

    localparam int unsigned INSN_WIDTH       = 8;
    localparam int unsigned DEFAULT_PC_WIDTH = 8;
    localparam logic [DEFAULT_PC_WIDTH-1:0] DEFAULT_RESET_PC = '0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDrop = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/insn_fetch.sv
// Instruction fetch stage: owns the PC, issues level req/ack reads to imem and
// holds one fetched instruction for the decoder, with stall and redirect.
module insn_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned           PC_WIDTH = DEFAULT_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [INSN_WIDTH-1:0] imem_rdata,
    input  logic                  imem_ack,
    input  logic                  stall,
    input  logic                  redirect_en,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic [INSN_WIDTH-1:0] insn,
    output logic                  insn_valid,
    output logic [PC_WIDTH-1:0]   insn_pc
);

    fetch_state_e          state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic [INSN_WIDTH-1:0] insn_q, insn_d;
    logic [PC_WIDTH-1:0]   insn_pc_q, insn_pc_d;
    logic                  insn_valid_q, insn_valid_d;
    logic                  consume;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            req_addr_q   <= '0;
            insn_q       <= '0;
            insn_pc_q    <= '0;
            insn_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            insn_q       <= insn_d;
            insn_pc_q    <= insn_pc_d;
            insn_valid_q <= insn_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        insn_d       = insn_q;
        insn_pc_d    = insn_pc_q;
        consume      = insn_valid_q & ~stall;
        insn_valid_d = insn_valid_q & ~consume;

        unique case (state_q)
            StIdle: begin
                if (redirect_en) begin
                    pc_d       = redirect_pc;
                    req_addr_d = redirect_pc;
                    state_d    = StReq;
                end else if (!insn_valid_q || consume) begin
                    req_addr_d = pc_q;
                    state_d    = StReq;
                end
            end
            StReq: begin
                if (imem_ack) begin
                    if (redirect_en) begin
                        // Returned data belongs to the old path; reissue at the target.
                        pc_d       = redirect_pc;
                        req_addr_d = redirect_pc;
                    end else begin
                        insn_d       = imem_rdata;
                        insn_pc_d    = req_addr_q;
                        insn_valid_d = 1'b1;
                        pc_d         = pc_q + PC_WIDTH'(1);
                        state_d      = StIdle;
                    end
                end else if (redirect_en) begin
                    // Request cannot be withdrawn under level handshake; wait it out.
                    pc_d    = redirect_pc;
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (redirect_en) begin
                    pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    req_addr_d = redirect_en ? redirect_pc : pc_q;
                    state_d    = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (redirect_en) begin
            insn_valid_d = 1'b0;
        end
    end

    assign imem_req   = (state_q == StReq) || (state_q == StDrop);
    assign imem_addr  = req_addr_q;
    assign insn       = insn_q;
    assign insn_valid = insn_valid_q;
    assign insn_pc    = insn_pc_q;

endmodule
